// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared types, default geometry and byte-lane merge for the data memory.
package data_mem_pkg;
  localparam int DM_DEPTH_WORDS = 4096;
  localparam int DM_IDX_W = 12;
  typedef enum logic [1:0] {DM_IDLE = 2'd0, DM_HI = 2'd1, DM_DONE = 2'd2} dm_state_t;
  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
    for (int i = 0; i < 4; i++) lane_merge[8*i +: 8] = sel[i] ? nw[8*i +: 8] : old[8*i +: 8];
  endfunction
endpackage

// File: rtl/data_mem_dm_word_ram.sv
// dm_word_ram: DEPTH_WORDS x 32 word array, asynchronous read, 4-lane byte write.
module dm_word_ram import data_mem_pkg::*; #(
  parameter int DEPTH_WORDS = DM_DEPTH_WORDS,
  parameter int IDX_W = DM_IDX_W
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       sel,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);
  logic [31:0] mem [DEPTH_WORDS];
  assign rdata = mem[idx];
  always_ff @(posedge clk)
    if (we) mem[idx] <= lane_merge(mem[idx], wdata, sel);
endmodule

// File: rtl/data_mem.sv
// data_mem: MEM-stage data memory; 32-bit single-cycle and 64-bit two-beat accesses.
// Optional range checking with err_o is enabled by defining DM_BOUNDS_CHK_EN.
module data_mem import data_mem_pkg::*; #(
  parameter int DEPTH_WORDS = DM_DEPTH_WORDS,
  parameter int IDX_W = DM_IDX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic        we64,
  input  logic        flg64,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [7:0]  sel64,
  input  logic [31:0] data_i,
  input  logic [63:0] data_i64,
  output logic [31:0] data_o,
  output logic [63:0] data_o64,
  output logic        stall_req,
  output logic        err_o
);
  dm_state_t        state;
  logic [IDX_W-1:0] lat_idx, ram_idx;
  logic [7:0]       lat_sel;
  logic [63:0]      lat_data;
  logic [31:0]      rd_lo, ram_wdata, ram_rdata;
  logic [3:0]       ram_sel;
  logic             lat_we, lat_oor, ram_we, req32, req64, in_hi, oor;
  assign req32 = state == DM_IDLE && ce && !flg64;
  assign req64 = state == DM_IDLE && ce && flg64;
  assign in_hi = state == DM_HI;
`ifdef DM_BOUNDS_CHK_EN
  assign oor = |addr[31:IDX_W+2];
  assign err_o = !rst && ((req32 && oor) || (state == DM_DONE && lat_oor));
`else
  assign oor = 1'b0;
  assign err_o = 1'b0;
`endif
  logic unused_ok;
  assign unused_ok = ^{addr[1:0], addr[31:IDX_W+2], lat_oor};
  // One shared RAM port: the high beat replays the latched request, so the bus may change freely.
  assign ram_idx = in_hi ? lat_idx + IDX_W'(1) : addr[IDX_W+1:2];
  assign ram_sel = in_hi ? lat_sel[7:4] : flg64 ? sel64[3:0] : sel;
  assign ram_wdata = in_hi ? lat_data[63:32] : flg64 ? data_i64[31:0] : data_i;
  assign ram_we = !rst && (in_hi ? lat_we && !lat_oor : ((req32 && we) || (req64 && we64)) && !oor);
  assign data_o = req32 && !oor ? ram_rdata : '0;
  assign stall_req = !rst && (req64 || in_hi);
  dm_word_ram #(.DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_ram (
    .clk(clk), .we(ram_we), .sel(ram_sel), .idx(ram_idx), .wdata(ram_wdata), .rdata(ram_rdata)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DM_IDLE;
      data_o64 <= '0;
    end else begin
      case (state)
        DM_IDLE: if (req64) begin
          lat_idx <= addr[IDX_W+1:2];
          lat_we <= we64;
          lat_sel <= sel64;
          lat_data <= data_i64;
          lat_oor <= oor;
          rd_lo <= oor ? '0 : ram_rdata;
          state <= DM_HI;
        end
        DM_HI: begin
          if (!lat_we) data_o64 <= lat_oor ? '0 : {ram_rdata, rd_lo};
          state <= DM_DONE;
        end
        default: state <= DM_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: randomized self-checking bench for data_mem against a word-array reference model.
module tb_data_mem;
  localparam int D = 4096;
  localparam int IW = 12;
  logic clk = 0, rst, ce, we, we64, flg64;
  logic [31:0] addr, data_i, data_o;
  logic [3:0] sel;
  logic [7:0] sel64;
  logic [63:0] data_i64, data_o64;
  logic stall_req, err_o;
  int checks = 0, fails = 0;
  logic [31:0] m [D];
  logic [63:0] exp64;

  data_mem dut (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .we64(we64), .flg64(flg64), .addr(addr),
    .sel(sel), .sel64(sel64), .data_i(data_i), .data_i64(data_i64), .data_o(data_o),
    .data_o64(data_o64), .stall_req(stall_req), .err_o(err_o)
  );
  always #5 clk = ~clk;

  function automatic bit is_oor(input logic [31:0] a);
`ifdef DM_BOUNDS_CHK_EN
    return a >= 32'(4 * D);
`else
    return 1'b0;
`endif
  endfunction
  function automatic int widx(input logic [31:0] a);
    return int'(a[IW+1:2]);
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction
  function automatic logic [31:0] mrd(input logic [31:0] a);
    return is_oor(a) ? 32'h0 : m[widx(a)];
  endfunction
  task automatic mwr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    if (!is_oor(a)) m[widx(a)] = merge(m[widx(a)], d, s);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic bus_idle();
    ce = 0; we = 0; we64 = 0; flg64 = 0; sel = 0; sel64 = 0; addr = 0; data_i = 0; data_i64 = 0;
  endtask
  task automatic set32(input logic [31:0] a, input logic w, input logic [3:0] s, input logic [31:0] d);
    ce = 1; flg64 = 0; we64 = 0; we = w; addr = a; sel = s; data_i = d;
    #1;
  endtask
  task automatic set64(input logic [31:0] a, input logic w, input logic [7:0] s, input logic [63:0] d);
    ce = 1; flg64 = 1; we64 = w; addr = a; sel64 = s; data_i64 = d; we = 1'($urandom); sel = 4'($urandom); data_i = $urandom;
    #1;
  endtask
  // Full 64-bit transaction; bus is scrambled in the high beat and the request re-presented in the last cycle.
  task automatic run64(input logic [31:0] a, input logic w, input logic [7:0] s, input logic [63:0] d,
                       output logic [2:0] st, output logic [2:0] er, output logic [63:0] o64, output logic [31:0] dq);
    set64(a, w, s, d);
    st[0] = stall_req; er[0] = err_o; dq = data_o;
    tick();
    ce = 1; flg64 = 1'($urandom); we = 1'($urandom); we64 = 1'($urandom); addr = $urandom; sel = 4'($urandom);
    sel64 = 8'($urandom); data_i = $urandom; data_i64 = {$urandom, $urandom};
    #1;
    st[1] = stall_req; er[1] = err_o;
    tick();
    set64(a, w, s, d);
    st[2] = stall_req; er[2] = err_o; o64 = data_o64;
    tick();
    bus_idle();
  endtask
  task automatic model64(input logic [31:0] a, input logic w, input logic [7:0] s, input logic [63:0] d);
    int lo = widx(a), hi = (widx(a) + 1) % D;
    if (is_oor(a)) begin
      if (!w) exp64 = 64'h0;
    end else if (w) begin
      m[lo] = merge(m[lo], d[31:0], s[3:0]);
      m[hi] = merge(m[hi], d[63:32], s[7:4]);
    end else exp64 = {m[hi], m[lo]};
  endtask

  task automatic test_reset();
    bus_idle();
    rst = 1;
    tick();
    tick();
    checks += 4;
    if (data_o64 !== 64'h0) begin fails++; $display("FAIL reset_data_o64 got=%h exp=0", data_o64); end
    if (stall_req !== 1'b0) begin fails++; $display("FAIL reset_stall got=%b exp=0", stall_req); end
    if (err_o !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", err_o); end
    if (data_o !== 32'h0) begin fails++; $display("FAIL reset_data_o got=%h exp=0", data_o); end
    rst = 0;
    exp64 = 64'h0;
  endtask

  task automatic init_mem();
    for (int i = 0; i < D; i++) begin
      logic [31:0] d = $urandom;
      set32(32'(4 * i), 1, 4'hF, d);
      tick();
      m[i] = d;
    end
    bus_idle();
  endtask

  task automatic test_directed();
    logic [2:0] st, er;
    logic [63:0] o64;
    logic [31:0] dq;
    set32(32'h10, 1, 4'hF, 32'hDEADBEEF); tick(); mwr(32'h10, 4'hF, 32'hDEADBEEF);
    set32(32'h10, 0, 4'hF, 32'h0);
    checks += 2;
    if (data_o !== 32'hDEADBEEF) begin fails++; $display("FAIL dir_rd32 got=%h exp=deadbeef", data_o); end
    if (stall_req !== 1'b0) begin fails++; $display("FAIL dir_stall32 got=%b exp=0", stall_req); end
    tick();
    set32(32'h10, 1, 4'b0010, 32'h0000AA00); tick(); mwr(32'h10, 4'b0010, 32'h0000AA00);
    set32(32'h10, 0, 4'hF, 32'h0);
    checks++;
    if (data_o !== 32'hDEADAAEF) begin fails++; $display("FAIL dir_lane_rd got=%h exp=deadaaef", data_o); end
    tick();
    run64(32'h20, 1, 8'hFF, 64'h11223344_55667788, st, er, o64, dq);
    model64(32'h20, 1, 8'hFF, 64'h11223344_55667788);
    checks += 2;
    if (st !== 3'b011) begin fails++; $display("FAIL dir_wr64_stall got=%b exp=011", st); end
    if (o64 !== exp64) begin fails++; $display("FAIL dir_wr64_hold got=%h exp=%h", o64, exp64); end
    run64(32'h20, 0, 8'hFF, 64'h0, st, er, o64, dq);
    model64(32'h20, 0, 8'hFF, 64'h0);
    checks += 3;
    if (st !== 3'b011) begin fails++; $display("FAIL dir_rd64_stall got=%b exp=011", st); end
    if (o64 !== 64'h11223344_55667788) begin fails++; $display("FAIL dir_rd64 got=%h exp=1122334455667788", o64); end
    if (data_o64 !== 64'h11223344_55667788) begin fails++; $display("FAIL dir_rd64_held got=%h exp=1122334455667788", data_o64); end
    set32(32'h24, 0, 4'hF, 32'h0);
    checks++;
    if (data_o !== 32'h11223344) begin fails++; $display("FAIL dir_rd_hi32 got=%h exp=11223344", data_o); end
    tick();
    bus_idle();
  endtask

  task automatic test_rand32();
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 4 * D - 1));
      logic [31:0] d = $urandom;
      logic [3:0] s = 4'($urandom);
      logic w = 1'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        bus_idle(); addr = a; we = w; sel = s; data_i = d;
        #1;
        checks += 2;
        if (data_o !== 32'h0) begin fails++; $display("FAIL r32_ce0_data got=%h exp=0", data_o); end
        if (stall_req !== 1'b0) begin fails++; $display("FAIL r32_ce0_stall got=%b exp=0", stall_req); end
        tick();
        continue;
      end
      set32(a, w, s, d);
      checks += 3;
      if (data_o !== mrd(a)) begin fails++; $display("FAIL r32_data a=%h got=%h exp=%h", a, data_o, mrd(a)); end
      if (err_o !== is_oor(a)) begin fails++; $display("FAIL r32_err a=%h got=%b exp=%b", a, err_o, is_oor(a)); end
      if (stall_req !== 1'b0) begin fails++; $display("FAIL r32_stall got=%b exp=0", stall_req); end
      tick();
      if (w) mwr(a, s, d);
    end
    bus_idle();
  endtask

  task automatic test_rand64();
    logic [2:0] st, er;
    logic [63:0] o64;
    logic [31:0] dq;
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 4 * D - 1));
      logic [63:0] d = {$urandom, $urandom};
      logic [7:0] s = 8'($urandom);
      logic w = 1'($urandom);
      logic [31:0] ahi;
      run64(a, w, s, d, st, er, o64, dq);
      model64(a, w, s, d);
      checks += 4;
      if (st !== 3'b011) begin fails++; $display("FAIL r64_stall a=%h got=%b exp=011", a, st); end
      if (er !== (is_oor(a) ? 3'b100 : 3'b000)) begin fails++; $display("FAIL r64_err a=%h got=%b", a, er); end
      if (o64 !== exp64) begin fails++; $display("FAIL r64_data a=%h w=%b got=%h exp=%h", a, w, o64, exp64); end
      if (dq !== 32'h0) begin fails++; $display("FAIL r64_data_o got=%h exp=0", dq); end
      ahi = {a[31:IW+2], IW'((widx(a) + 1) % D), 2'b00};
      set32(ahi, 0, 4'hF, 32'h0);
      checks++;
      if (data_o !== mrd(ahi)) begin fails++; $display("FAIL r64_hiword a=%h got=%h exp=%h", ahi, data_o, mrd(ahi)); end
      tick();
      bus_idle();
    end
  endtask

  task automatic test_wrap();
    logic [2:0] st, er;
    logic [63:0] o64;
    logic [31:0] dq;
    logic [63:0] d = {$urandom, $urandom};
    run64(32'(4 * (D - 1)), 1, 8'hFF, d, st, er, o64, dq);
    model64(32'(4 * (D - 1)), 1, 8'hFF, d);
    set32(32'h0, 0, 4'hF, 32'h0);
    checks++;
    if (data_o !== d[63:32]) begin fails++; $display("FAIL wrap_word0 got=%h exp=%h", data_o, d[63:32]); end
    tick();
    set32(32'(4 * (D - 1)), 0, 4'hF, 32'h0);
    checks++;
    if (data_o !== d[31:0]) begin fails++; $display("FAIL wrap_last got=%h exp=%h", data_o, d[31:0]); end
    tick();
    bus_idle();
  endtask

  task automatic test_rst_fsm();
    logic [63:0] d = {$urandom | 32'h1, $urandom | 32'h1};
    logic [31:0] old_hi = m[17];
    set64(32'h40, 1, 8'hFF, d);
    tick();
    rst = 1;
    tick();
    rst = 0;
    m[16] = d[31:0];
    set32(32'h44, 0, 4'hF, 32'h0);
    checks += 2;
    if (stall_req !== 1'b0) begin fails++; $display("FAIL rst_hi_stall got=%b exp=0", stall_req); end
    if (data_o !== old_hi) begin fails++; $display("FAIL rst_hi_hiword got=%h exp=%h", data_o, old_hi); end
    tick();
    set32(32'h40, 0, 4'hF, 32'h0);
    checks++;
    if (data_o !== d[31:0]) begin fails++; $display("FAIL rst_hi_loword got=%h exp=%h", data_o, d[31:0]); end
    tick();
    set64(32'h40, 0, 8'hFF, 64'h0);
    tick();
    tick();
    checks++;
    if (data_o64 !== {old_hi, d[31:0]}) begin fails++; $display("FAIL rst_done_pre got=%h exp=%h", data_o64, {old_hi, d[31:0]}); end
    rst = 1;
    bus_idle();
    tick();
    rst = 0;
    exp64 = 64'h0;
    checks++;
    if (data_o64 !== 64'h0) begin fails++; $display("FAIL rst_done_clear got=%h exp=0", data_o64); end
  endtask

  task automatic test_bounds();
    logic [31:0] d = $urandom | 32'h1;
    logic [31:0] a = 32'(4 * D);
    logic [31:0] w0;
    set32(a, 1, 4'hF, d);
    checks++;
    if (err_o !== is_oor(a)) begin fails++; $display("FAIL bnd_err got=%b exp=%b", err_o, is_oor(a)); end
    tick();
    mwr(a, 4'hF, d);
    bus_idle();
    #1;
    checks++;
    if (err_o !== 1'b0) begin fails++; $display("FAIL bnd_err_pulse got=%b exp=0", err_o); end
    w0 = m[0];
    set32(32'h0, 0, 4'hF, 32'h0);
    checks++;
    if (data_o !== w0) begin fails++; $display("FAIL bnd_word0 got=%h exp=%h", data_o, w0); end
    tick();
    set32(a, 0, 4'hF, 32'h0);
    checks++;
    if (data_o !== mrd(a)) begin fails++; $display("FAIL bnd_rdback got=%h exp=%h", data_o, mrd(a)); end
    tick();
    bus_idle();
  endtask

  initial begin
    test_reset();
    init_mem();
    test_directed();
    test_rand32();
    test_rand64();
    test_wrap();
    test_rst_fsm();
    test_bounds();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
